// File: rtl/ram_loader_pkg.sv
// Shared types for the RAM loader slice.
//   pkg_ram    : RAM address width and RAM operation / access size encodings.
//   pkg_loader : loader FSM states and stream framing constants.
package pkg_ram;

  localparam int unsigned RAM_ADDRW = 17;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_LOAD  = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_HALF = 2'd1,
    RAM_WORD = 2'd2,
    RAM_QUAD = 2'd3
  } ram_size_t;

endpackage

package pkg_loader;

  localparam int unsigned LEN_BYTES  = 4;
  localparam int unsigned QUAD_BYTES = 8;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    QCOL,
    QST,
    BCOL,
    BST,
    SUM,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/ram_loader_quad_pack.sv
// loader_quad_pack: 64-bit shift-in byte packer for quad stores.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of fill counter and packed bytes
//   shift      : shift din in (first byte of a group ends up in [63:56])
//   din        : incoming byte
//   data       : packed group including the byte currently on din
//   full       : the next shift completes an 8-byte group
module loader_quad_pack
  import pkg_loader::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic [63:0] data,
  output logic        full
);

  // Only the 7 most recent bytes are kept; the 8th is taken straight from din
  // so the completed group is available on the edge that accepts it.
  logic [55:0] data_q;
  logic [2:0]  fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      data_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      data_q <= {data_q[47:0], din};
      fill_q <= fill_q + 3'd1;
    end
  end

  assign data = {data_q, din};
  assign full = (fill_q == 3'(QUAD_BYTES - 1));

endmodule

// File: rtl/ram_loader.sv
// ram_loader: loads a length-prefixed byte image into RAM.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : arms a load (accepted in IDLE or ERROR)
//   rx_data/valid/ready   : incoming byte stream (4-byte big-endian length, then payload)
//   ram_op/size/addr/data_in : store command; quads for full 8-byte groups, bytes for the tail
//   tx_data/valid/ready   : 8-bit payload checksum handshake
//   busy                  : high except in IDLE and ERROR
//   done                  : one-cycle pulse after the checksum handshake
//   err                   : sticky length error, cleared by the next accepted start
module ram_loader
  import pkg_ram::*, pkg_loader::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned RAM_ADDRW = pkg_ram::RAM_ADDRW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output ram_op_t              ram_op,
  output ram_size_t            ram_size,
  output logic [RAM_ADDRW-1:0] ram_addr,
  output logic [63:0]          ram_data_in,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned RW1 = RAM_ADDRW + 1;
  localparam logic [RW1-1:0] QUAD_N = RW1'(QUAD_BYTES);
  localparam logic [32:0] CAPACITY = (33'd1 << RAM_ADDRW) - 33'(BASE_ADDR);

  loader_state_t state;
  loader_state_t fill_next;
  logic [23:0]   len_q;
  logic [1:0]    len_cnt;
  logic [RW1-1:0] rem_q;
  logic [RW1-1:0] rem_next;
  logic [7:0]    csum_q;
  logic [31:0]   n_len;
  logic          len_too_big;
  logic          rx_acc;
  logic          start_acc;
  logic [63:0]   pack_data;
  logic          pack_full;

  assign rx_acc      = rx_valid && rx_ready;
  assign start_acc   = start && ((state == IDLE) || (state == ERROR));
  assign n_len       = {len_q, rx_data};
  assign len_too_big = ({1'b0, n_len} > CAPACITY);

  loader_quad_pack u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_acc),
    .shift (rx_acc && (state == QCOL)),
    .din   (rx_data),
    .data  (pack_data),
    .full  (pack_full)
  );

  // Remaining byte count after the current step, and the collect/sum state it
  // leads to. Shared by the length decode and both store states.
  always_comb begin
    rem_next = rem_q;
    unique case (state)
      LEN:     rem_next = n_len[RW1-1:0];
      QST:     rem_next = rem_q - QUAD_N;
      BST:     rem_next = rem_q - RW1'(1);
      default: rem_next = rem_q;
    endcase
    if (rem_next == '0) begin
      fill_next = SUM;
    end else if (rem_next >= QUAD_N) begin
      fill_next = QCOL;
    end else begin
      fill_next = BCOL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_ready    <= 1'b0;
      ram_op      <= RAM_NOP;
      ram_size    <= RAM_BYTE;
      ram_addr    <= RAM_ADDRW'(BASE_ADDR);
      ram_data_in <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      len_q       <= '0;
      len_cnt     <= '0;
      rem_q       <= '0;
      csum_q      <= '0;
    end else begin
      // Store command and done are single-cycle; they fall back every cycle.
      ram_op      <= RAM_NOP;
      ram_size    <= RAM_BYTE;
      ram_data_in <= '0;
      done        <= 1'b0;

      unique case (state)
        IDLE, ERROR: begin
          if (start) begin
            state    <= LEN;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            csum_q   <= '0;
            len_cnt  <= '0;
            ram_addr <= RAM_ADDRW'(BASE_ADDR);
          end
        end

        LEN: begin
          if (rx_acc) begin
            len_q   <= {len_q[15:0], rx_data};
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'(LEN_BYTES - 1)) begin
              if (len_too_big) begin
                state    <= ERROR;
                rx_ready <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b1;
              end else begin
                rem_q    <= rem_next;
                state    <= fill_next;
                rx_ready <= (fill_next != SUM);
                tx_valid <= (fill_next == SUM);
                tx_data  <= csum_q;
              end
            end
          end
        end

        QCOL: begin
          if (rx_acc) begin
            csum_q <= csum_q + rx_data;
            if (pack_full) begin
              state       <= QST;
              rx_ready    <= 1'b0;
              ram_op      <= RAM_STORE;
              ram_size    <= RAM_QUAD;
              ram_data_in <= pack_data;
            end
          end
        end

        QST: begin
          rem_q    <= rem_next;
          // Address only advances when another store follows, so it never wraps.
          if (fill_next != SUM) begin
            ram_addr <= ram_addr + RAM_ADDRW'(QUAD_BYTES);
          end
          state    <= fill_next;
          rx_ready <= (fill_next != SUM);
          tx_valid <= (fill_next == SUM);
          tx_data  <= csum_q;
        end

        BCOL: begin
          if (rx_acc) begin
            csum_q      <= csum_q + rx_data;
            state       <= BST;
            rx_ready    <= 1'b0;
            ram_op      <= RAM_STORE;
            ram_data_in <= {56'd0, rx_data};
          end
        end

        BST: begin
          rem_q <= rem_next;
          if (fill_next != SUM) begin
            ram_addr <= ram_addr + RAM_ADDRW'(1);
          end
          state    <= fill_next;
          rx_ready <= (fill_next != SUM);
          tx_valid <= (fill_next == SUM);
          tx_data  <= csum_q;
        end

        SUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= DONE;
            done     <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized self-checking bench for ram_loader against a
// queue-based model of the expected store list and checksum.
module tb_ram_loader;
  import pkg_ram::*;

  localparam int unsigned AW = 17;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  ram_op_t         ram_op;
  ram_size_t       ram_size;
  logic [AW-1:0]   ram_addr;
  logic [63:0]     ram_data_in;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic            done;
  logic            err;

  ram_loader #(.BASE_ADDR(0), .RAM_ADDRW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .ram_op      (ram_op),
    .ram_size    (ram_size),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        quad;
    int unsigned addr;
    logic [63:0] data;
  } store_t;

  store_t      obs_q[$];
  store_t      exp_q[$];
  logic [7:0]  pl_q[$];
  logic [7:0]  exp_cs;
  int unsigned done_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(negedge clk) begin
    if (ram_op == RAM_STORE)
      obs_q.push_back('{quad: (ram_size == RAM_QUAD), addr: 32'(ram_addr), data: ram_data_in});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected stores: floor(N/8) quads at 8*k, then one byte store per tail byte.
  task automatic build_model();
    int unsigned n = pl_q.size();
    int unsigned nq = n / 8;
    logic [63:0] d;
    exp_q.delete();
    exp_cs = 8'h00;
    for (int unsigned q = 0; q < nq; q++) begin
      d = 64'd0;
      for (int unsigned k = 0; k < 8; k++) d = (d << 8) | 64'(pl_q[q*8 + k]);
      exp_q.push_back('{quad: 1'b1, addr: q*8, data: d});
    end
    for (int unsigned i = nq*8; i < n; i++)
      exp_q.push_back('{quad: 1'b0, addr: i, data: 64'(pl_q[i])});
    for (int unsigned i = 0; i < n; i++) exp_cs = exp_cs + pl_q[i];
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned w = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) check("rx_ready_wait", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    obs_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int k = 3; k >= 0; k--) send_byte(n[k*8 +: 8], 1'b0);
  endtask

  task automatic send_payload(input bit gaps);
    for (int unsigned i = 0; i < pl_q.size(); i++) send_byte(pl_q[i], gaps);
  endtask

  task automatic finish_tx(input int unsigned hold);
    int unsigned w = 0;
    int unsigned d0;
    while (!tx_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("tx_valid", 64'(tx_valid), 64'd1);
    check("tx_data", 64'(tx_data), 64'(exp_cs));
    repeat (hold) begin
      @(negedge clk);
      check("tx_hold_valid", 64'(tx_valid), 64'd1);
      check("tx_hold_data", 64'(tx_data), 64'(exp_cs));
      check("no_early_done", 64'(done), 64'd0);
    end
    d0 = done_cnt;
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("err_after", 64'(err), 64'd0);
  endtask

  task automatic compare_stores();
    int unsigned m;
    check("store_count", 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int unsigned i = 0; i < m; i++) begin
      check("store_quad", 64'(obs_q[i].quad), 64'(exp_q[i].quad));
      check("store_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check("store_data", obs_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic run_load(input bit gaps, input int unsigned hold);
    build_model();
    do_start();
    check("busy_start", 64'(busy), 64'd1);
    send_len(32'(pl_q.size()));
    send_payload(gaps);
    finish_tx(hold);
    compare_stores();
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", 64'(rx_ready), 64'd0);
    check("rst_ram_op", 64'(ram_op), 64'(RAM_NOP));
    check("rst_ram_size", 64'(ram_size), 64'(RAM_BYTE));
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_data", ram_data_in, 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
  endtask

  task automatic fill_seq(input int unsigned n, input logic [7:0] first);
    pl_q.delete();
    for (int unsigned i = 0; i < n; i++) pl_q.push_back(first + 8'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Two full quads
    fill_seq(16, 8'h00);
    run_load(1'b0, 0);
    check("t1_checksum", 64'(tx_data), 64'h78);

    // One quad plus three-byte tail
    fill_seq(11, 8'h01);
    run_load(1'b0, 0);
    check("t2_checksum", 64'(tx_data), 64'h42);

    // Empty image
    pl_q.delete();
    run_load(1'b0, 2);

    // Oversized length, then recovery from ERROR
    do_start();
    send_len(32'h0002_0001);
    check("err_set", 64'(err), 64'd1);
    check("err_rx_ready", 64'(rx_ready), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    check("err_rx_ready_hold", 64'(rx_ready), 64'd0);
    check("err_sticky", 64'(err), 64'd1);
    check("err_no_store", 64'(obs_q.size()), 64'd0);
    pl_q.delete();
    pl_q.push_back(8'hFF);
    build_model();
    do_start();
    check("err_cleared", 64'(err), 64'd0);
    send_len(32'd1);
    send_payload(1'b0);
    finish_tx(0);
    compare_stores();

    // Gapped input with a stalled checksum consumer
    fill_seq(16, 8'h00);
    run_load(1'b1, 5);

    // Reset in the middle of a load
    fill_seq(16, 8'h00);
    do_start();
    send_len(32'd16);
    for (int unsigned i = 0; i < 5; i++) send_byte(pl_q[i], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    check("rst_no_store", 64'(obs_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(1'b0, 0);

    // Random images
    for (int it = 0; it < 6; it++) begin
      pl_q.delete();
      repeat ($urandom_range(1, 40)) pl_q.push_back(8'($urandom));
      run_load(1'b1, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
